// File: rtl/btn_edge_capture_pkg.sv
// btn_edge_capture_pkg: shared debounce state encoding and default sizes
package btn_edge_capture_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_RISE = 2'd1,
        S_HI   = 2'd2,
        S_FALL = 2'd3
    } db_state_t;

    localparam int DB_CNT_MAX_DEF = 200000;
    localparam int CNT_W_DEF      = 20;
    localparam int SW_W           = 24;

endpackage

// File: rtl/btn_edge_capture_if.sv
// btn_edge_capture_if: raw front-panel inputs and CPU-side flag/switch bus
interface btn_edge_capture_if;
    import btn_edge_capture_pkg::*;

    logic            btn_submit_raw;
    logic            btn_status_raw;
    logic [SW_W-1:0] switches_raw;
    logic            clr_submit;
    logic            clr_status;
    logic [SW_W-1:0] switches;
    logic            submit_posedge;
    logic            status_posedge;
    logic            submit_level;
    logic            status_level;

    modport master (
        output btn_submit_raw, btn_status_raw, switches_raw, clr_submit, clr_status,
        input  switches, submit_posedge, status_posedge, submit_level, status_level
    );

    modport slave (
        input  btn_submit_raw, btn_status_raw, switches_raw, clr_submit, clr_status,
        output switches, submit_posedge, status_posedge, submit_level, status_level
    );

endinterface

// File: rtl/btn_edge_capture_debounce_fsm.sv
// debounce_fsm: synchronizes one button and accepts level changes after a stable run
module debounce_fsm
    import btn_edge_capture_pkg::*;
#(
    parameter int DB_CNT_MAX = DB_CNT_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

    logic [1:0]       sync;
    logic             sync_in;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    // two-flop synchronizer for the asynchronous button
    always_ff @(posedge clock or posedge reset)
        if (reset) sync <= '0;
        else       sync <= {sync[0], raw};

    assign sync_in = sync[1];

    // rise fires in the last stable cycle so the sticky flag sets on the acceptance edge
    assign rise = (state == S_RISE) && sync_in && (cnt == CNT_LAST);

    // debounce FSM: a change is accepted only after DB_CNT_MAX stable cycles in the pending state
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= S_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            case (state)
                S_LO:
                    if (sync_in) begin
                        state <= S_RISE;
                        cnt   <= '0;
                    end
                S_RISE:
                    if (!sync_in) begin
                        state <= S_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HI;
                        cnt   <= '0;
                        level <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                S_HI:
                    if (!sync_in) begin
                        state <= S_FALL;
                        cnt   <= '0;
                    end
                S_FALL:
                    if (sync_in) begin
                        state <= S_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                default: begin
                    state <= S_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end

endmodule

// File: rtl/btn_edge_capture.sv
// btn_edge_capture: debounced button press flags with read-clear, plus synchronized switches
module btn_edge_capture
    import btn_edge_capture_pkg::*;
#(
    parameter int DB_CNT_MAX = DB_CNT_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    btn_edge_capture_if.slave bus
);

    logic            submit_rise;
    logic            status_rise;
    logic [SW_W-1:0] sw_meta;

    debounce_fsm #(.DB_CNT_MAX(DB_CNT_MAX), .CNT_W(CNT_W)) u_submit (
        .clock (clock),
        .reset (reset),
        .raw   (bus.btn_submit_raw),
        .level (bus.submit_level),
        .rise  (submit_rise)
    );

    debounce_fsm #(.DB_CNT_MAX(DB_CNT_MAX), .CNT_W(CNT_W)) u_status (
        .clock (clock),
        .reset (reset),
        .raw   (bus.btn_status_raw),
        .level (bus.status_level),
        .rise  (status_rise)
    );

    // switches only need synchronizing, the CPU samples them on demand
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            sw_meta      <= '0;
            bus.switches <= '0;
        end else begin
            sw_meta      <= bus.switches_raw;
            bus.switches <= sw_meta;
        end

    // sticky press flags: a new press beats a simultaneous read-clear so no press is lost
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            bus.submit_posedge <= 1'b0;
            bus.status_posedge <= 1'b0;
        end else begin
            bus.submit_posedge <= submit_rise ? 1'b1 : bus.clr_submit ? 1'b0 : bus.submit_posedge;
            bus.status_posedge <= status_rise ? 1'b1 : bus.clr_status ? 1'b0 : bus.status_posedge;
        end

endmodule

// File: tb/tb_btn_edge_capture.sv
// tb_btn_edge_capture: random and directed checks against a run-length debounce model
module tb_btn_edge_capture;

    localparam int DB = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    btn_edge_capture_if bus ();

    btn_edge_capture #(.DB_CNT_MAX(DB), .CNT_W(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // reference model: each button is a 2-cycle delay line feeding a run-length
    // acceptor; index 0 = submit, 1 = status
    logic        m_d1 [2];
    logic        m_d2 [2];
    logic        m_lvl [2];
    int          m_run [2];
    logic        m_flag [2];
    logic [23:0] m_sw1, m_sw2;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_flag[b] = 0;
        end
        m_sw1 = '0; m_sw2 = '0;
    endtask

    task automatic model_edge();
        logic raw [2];
        logic clr [2];
        logic s, ev;
        raw[0] = bus.btn_submit_raw; raw[1] = bus.btn_status_raw;
        clr[0] = bus.clr_submit;     clr[1] = bus.clr_status;
        for (int b = 0; b < 2; b++) begin
            s  = m_d2[b];
            ev = 0;
            if (s != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB + 1) begin
                    m_lvl[b] = s;
                    m_run[b] = 0;
                    ev = s;
                end
            end else m_run[b] = 0;
            m_flag[b] = ev ? 1'b1 : clr[b] ? 1'b0 : m_flag[b];
            m_d2[b] = m_d1[b];
            m_d1[b] = raw[b];
        end
        m_sw2 = m_sw1;
        m_sw1 = bus.switches_raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs();
        chk("submit_posedge", 32'(bus.submit_posedge), 32'(m_flag[0]));
        chk("status_posedge", 32'(bus.status_posedge), 32'(m_flag[1]));
        chk("submit_level",   32'(bus.submit_level),   32'(m_lvl[0]));
        chk("status_level",   32'(bus.status_level),   32'(m_lvl[1]));
        chk("switches",       32'(bus.switches),       32'(m_sw2));
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_outs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outs();
        cycles(2);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_submit_flag();
        lat = 0;
        while (!bus.submit_posedge && lat < 20) begin
            cycle();
            lat++;
        end
    endtask

    initial begin
        bus.btn_submit_raw = 0;
        bus.btn_status_raw = 0;
        bus.switches_raw   = '0;
        bus.clr_submit     = 0;
        bus.clr_status     = 0;
        model_reset();
        #1;
        chk("reset_submit_flag", 32'(bus.submit_posedge), 0);
        chk("reset_status_flag", 32'(bus.status_posedge), 0);
        chk("reset_switches",    32'(bus.switches),       0);
        cycles(2);
        @(negedge clock);
        reset = 1'b0;
        cycles(2);

        // switch path: exactly two clocks
        bus.switches_raw = 24'hA5C3F0;
        cycle();
        chk("sw_1clk", 32'(bus.switches), 32'h0);
        cycle();
        chk("sw_2clk", 32'(bus.switches), 32'hA5C3F0);

        // clean press
        bus.btn_submit_raw = 1;
        wait_submit_flag();
        chk("press_latency", lat, DB + 3);
        cycles(20 - lat);
        chk("press_level",   32'(bus.submit_level),   1);
        chk("press_status0", 32'(bus.status_posedge), 0);

        // read clear while held
        bus.clr_submit = 1;
        chk("clr_read_same_cycle", 32'(bus.submit_posedge), 1);
        cycle();
        bus.clr_submit = 0;
        chk("clr_after", 32'(bus.submit_posedge), 0);
        cycles(10);
        chk("held_no_reset", 32'(bus.submit_posedge), 0);
        bus.btn_submit_raw = 0;
        cycles(12);

        // bounce then steady high
        bus.btn_submit_raw = 1; cycle();
        bus.btn_submit_raw = 0; cycle();
        bus.btn_submit_raw = 1; cycle();
        bus.btn_submit_raw = 1; cycle();
        bus.btn_submit_raw = 0; cycle();
        chk("bounce_no_flag", 32'(bus.submit_posedge), 0);
        bus.btn_submit_raw = 1;
        wait_submit_flag();
        chk("bounce_latency", lat, DB + 3);
        bus.clr_submit = 1; cycle(); bus.clr_submit = 0;
        bus.btn_submit_raw = 0;
        cycles(12);

        // clear colliding with the status rise event
        bus.btn_status_raw = 1;
        cycles(DB + 2);
        bus.clr_status = 1;
        cycle();
        bus.clr_status = 0;
        chk("collision_set_wins", 32'(bus.status_posedge), 1);
        bus.btn_status_raw = 0;
        cycles(12);

        // reset mid-debounce abandons the press
        bus.btn_submit_raw = 1;
        cycles(3);
        bus.btn_submit_raw = 0;
        pulse_reset();
        chk("midrst_level", 32'(bus.submit_level), 0);
        cycles(15);
        chk("midrst_no_flag", 32'(bus.submit_posedge), 0);

        // button held through reset is a fresh press
        bus.btn_submit_raw = 1;
        cycles(10);
        pulse_reset();
        cycles(15);
        chk("held_at_reset_flag", 32'(bus.submit_posedge), 1);
        bus.btn_submit_raw = 0;
        cycles(12);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 6) == 0) bus.btn_submit_raw = ~bus.btn_submit_raw;
            if ($urandom_range(0, 6) == 0) bus.btn_status_raw = ~bus.btn_status_raw;
            bus.clr_submit   = ($urandom_range(0, 9) == 0);
            bus.clr_status   = ($urandom_range(0, 9) == 0);
            bus.switches_raw = 24'($urandom);
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
